iir_tap_seq: RTL
================

IIR_TAP_SEQ -- requirements
Module: iir_tap_seq

Interface
REQ-001 SHALL have parameter W, default 8, sample/coefficient/MAC operand width (signed two's complement).
REQ-002 SHALL have parameter FRAC, default 6, coefficient fractional bits (64 = 1.0 at default).
REQ-003 SHALL have ports clk in 1 clock; reset in 1 reset, synchronous, active-high.
REQ-004 SHALL have ports in_valid in 1, in_ready out 1, in_data in W: input sample handshake.
REQ-005 SHALL have ports out_valid out 1, out_data out W: filtered sample, one-cycle strobe.
REQ-006 SHALL have ports coef_we in 1, coef_addr in 3, coef_data in W: coefficient write (0..2 = b0..b2, 3..4 = a1..a2).
REQ-007 SHALL have ports mac_start out 1, mac_clr out 1, mac_a out W, mac_b out W: drive to downstream MAC.
REQ-008 SHALL have ports mac_ready in 1, mac_acc in 2W: MAC status and accumulator.

Function
REQ-009 SHALL compute y[n] = b0*x[n] + b1*x[n-1] + b2*x[n-2] + a1*y[n-1] + a2*y[n-2]; feedback sign is carried in stored a1/a2.
REQ-010 SHALL implement FSM IDLE -> CLR -> ISSUE -> WAIT_LO -> WAIT_HI -> (ISSUE if taps remain, else OUT) -> SHIFT -> IDLE.
REQ-011 IDLE: in_ready=1; in_valid=1 latches in_data as x[n] and moves to CLR; in_ready=0 in all other states.
REQ-012 CLR: mac_clr=1 for exactly one cycle; tap index set to 0.
REQ-013 ISSUE: entered only with mac_ready=1; mac_start=1 for one cycle with mac_a=coefficient[tap], mac_b=operand[tap]; mac_a/mac_b held stable until WAIT_HI exits.
REQ-014 WAIT_LO: one cycle, mac_ready ignored; WAIT_HI: wait for mac_ready=1, then advance tap; no timeout.
REQ-015 Tap order SHALL be b0/x[n], b1/x[n-1], b2/x[n-2], a1/y[n-1], a2/y[n-2]; five MAC operations per sample.
REQ-016 OUT: result r = mac_acc arithmetic-shifted right by FRAC; out_data = r reduced to W bits (see REQ-023); out_valid=1 for one cycle.
REQ-017 SHIFT: x[n-2]<=x[n-1], x[n-1]<=x[n], y[n-2]<=y[n-1], y[n-1]<=out_data.
REQ-018 Coefficient writes SHALL be accepted only in IDLE; writes in other states or with coef_addr>4 SHALL be ignored.
REQ-019 Simultaneous coef_we and in_valid in IDLE: both accepted; the written coefficient applies to that sample.
REQ-020 mac_acc SHALL wrap at 2W bits (no accumulator overflow detection); out_data held between strobes.

Reset
REQ-021 reset SHALL force IDLE, in_ready=1, out_valid=0, out_data=0, mac_start=0, mac_a=mac_b=0, all coefficients and delay-line entries=0.
REQ-022 mac_clr SHALL be asserted while reset=1; reset mid-operation aborts the sample with no out_valid.

Configuration
REQ-023 With IIR_SATURATE_EN defined, r SHALL clamp to [-2^(W-1), 2^(W-1)-1]; without it, out_data = r[W-1:0] (wrap).

Structure
REQ-024 SHALL take state enum, tap-index type, and coefficient address constants from shared package iir_pkg.
REQ-025 SHALL contain no sub-module; the MAC SHALL be instantiated beside it at filter top level.

Verification
REQ-026 b0=64, others 0; in 48 -> out 48; in -48 -> out -48.
REQ-027 b0=b1=64; inputs 10, 20, 0 -> outputs 10, 30, 20.
REQ-028 b0=64, a1=32; impulse 64, 0, 0, 0 -> outputs 64, 32, 16, 8.
REQ-029 b0=127; in 127 -> out 127 with IIR_SATURATE_EN, -4 without.
REQ-030 Assert reset during WAIT_HI of tap 3 -> no out_valid, in_ready=1 next cycle, next sample output equals b0*x only (zero history and coefficients require reload).
REQ-031 Hold mac_ready low 20 cycles in WAIT_HI -> FSM stalls, mac_a/mac_b stable, in_ready=0, no out_valid.

Source files
------------

// File: rtl/iir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iir_pkg
// Purpose  : Shared types and constants for the IIR tap sequencer: FSM state
//            encoding, tap-index type and coefficient address map.
// Revision : 1.0 - initial release
// ============================================================================
package iir_pkg;

  // Sequencer states; encoding width is explicit so the register is 3 bits.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLR     = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_WAIT_HI = 3'd4,
    ST_OUT     = 3'd5,
    ST_SHIFT   = 3'd6
  } state_t;

  // Tap index doubles as coefficient address: tap k multiplies coefficient k.
  typedef logic [2:0] tap_t;

  localparam tap_t c_addr_b0 = 3'd0;
  localparam tap_t c_addr_b1 = 3'd1;
  localparam tap_t c_addr_b2 = 3'd2;
  localparam tap_t c_addr_a1 = 3'd3;
  localparam tap_t c_addr_a2 = 3'd4;

  localparam int   c_num_taps = 5;
  localparam tap_t c_last_tap = c_addr_a2;

endpackage : iir_pkg
`default_nettype wire

// File: rtl/iir_tap_seq.sv
`default_nettype none
// ============================================================================
// Module   : iir_tap_seq
// Purpose  : Sequences one biquad IIR sample through an external MAC:
//            y[n] = b0*x[n] + b1*x[n-1] + b2*x[n-2] + a1*y[n-1] + a2*y[n-2]
//            Feedback sign lives in the stored a1/a2 values.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            in_valid/in_ready/in_data   - input sample handshake
//            out_valid/out_data          - result strobe, data held between
//            coef_we/coef_addr/coef_data - coefficient write (IDLE only)
//            mac_start/mac_clr/mac_a/mac_b - commands to the MAC
//            mac_ready/mac_acc             - MAC status and accumulator
// Config   : IIR_SATURATE_EN - clamp the scaled result to the W-bit signed
//            range instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module iir_tap_seq
  import iir_pkg::*;
#(
  parameter int W    = 8,
  parameter int FRAC = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  input  logic           coef_we,
  input  logic [2:0]     coef_addr,
  input  logic [W-1:0]   coef_data,
  output logic           mac_start,
  output logic           mac_clr,
  output logic [W-1:0]   mac_a,
  output logic [W-1:0]   mac_b,
  input  logic           mac_ready,
  input  logic [2*W-1:0] mac_acc
);

  localparam logic signed [2*W-1:0] c_sat_max = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] c_sat_min = {{(W+1){1'b1}}, {(W-1){1'b0}}};

  state_t       r_state, w_state_nxt;
  tap_t         r_tap, w_tap_nxt;
  logic [W-1:0] r_coef [c_num_taps];
  logic [W-1:0] r_x0, r_x1, r_x2, r_y1, r_y2;
  logic [W-1:0] r_mac_a, r_mac_b;
  logic [W-1:0] r_out_data;
  logic         r_out_valid;
  logic         r_clr_done;
  logic [W-1:0] w_sel_coef, w_sel_opnd;
  logic signed [2*W-1:0] w_shifted;
  logic [W-1:0] w_result;

  // Next-state logic.  CLR holds until the MAC reports ready so that ISSUE
  // is only ever entered with mac_ready high.
  always_comb begin
    w_state_nxt = r_state;
    w_tap_nxt   = r_tap;
    case (r_state)
      ST_IDLE:    if (in_valid) w_state_nxt = ST_CLR;
      ST_CLR: begin
        w_tap_nxt = c_addr_b0;
        if (mac_ready) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE:   w_state_nxt = ST_WAIT_LO;
      ST_WAIT_LO: w_state_nxt = ST_WAIT_HI;
      ST_WAIT_HI: begin
        if (mac_ready) begin
          if (r_tap == c_last_tap) begin
            w_state_nxt = ST_OUT;
          end else begin
            w_tap_nxt   = r_tap + 3'd1;
            w_state_nxt = ST_ISSUE;
          end
        end
      end
      ST_OUT:     w_state_nxt = ST_SHIFT;
      ST_SHIFT:   w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand pair for the tap about to be issued.
  always_comb begin
    w_sel_coef = r_coef[c_addr_b0];
    w_sel_opnd = r_x0;
    case (w_tap_nxt)
      c_addr_b1: begin w_sel_coef = r_coef[c_addr_b1]; w_sel_opnd = r_x1; end
      c_addr_b2: begin w_sel_coef = r_coef[c_addr_b2]; w_sel_opnd = r_x2; end
      c_addr_a1: begin w_sel_coef = r_coef[c_addr_a1]; w_sel_opnd = r_y1; end
      c_addr_a2: begin w_sel_coef = r_coef[c_addr_a2]; w_sel_opnd = r_y2; end
      default: ;
    endcase
  end

  // Scale the Q(FRAC) accumulator back to sample units.
  assign w_shifted = $signed(mac_acc) >>> FRAC;

`ifdef IIR_SATURATE_EN
  always_comb begin
    if (w_shifted > c_sat_max)      w_result = c_sat_max[W-1:0];
    else if (w_shifted < c_sat_min) w_result = c_sat_min[W-1:0];
    else                            w_result = w_shifted[W-1:0];
  end
`else
  // Wrap mode keeps only the low W bits; the rest are intentionally dropped.
  logic w_unused_hi;
  assign w_result    = w_shifted[W-1:0];
  assign w_unused_hi = ^w_shifted[2*W-1:W];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_tap       <= c_addr_b0;
      r_x0        <= '0;
      r_x1        <= '0;
      r_x2        <= '0;
      r_y1        <= '0;
      r_y2        <= '0;
      r_mac_a     <= '0;
      r_mac_b     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_clr_done  <= 1'b0;
      for (int i = 0; i < c_num_taps; i++) r_coef[i] <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_tap       <= w_tap_nxt;
      r_out_valid <= 1'b0;
      r_clr_done  <= (r_state == ST_CLR);

      if (r_state == ST_IDLE) begin
        if (in_valid) r_x0 <= in_data;
        // Write lands before the first ISSUE, so it applies to a sample
        // accepted on the same cycle.
        if (coef_we && (coef_addr <= c_addr_a2)) r_coef[coef_addr] <= coef_data;
      end

      // Operands load on entry to ISSUE and stay put until WAIT_HI exits.
      if (w_state_nxt == ST_ISSUE) begin
        r_mac_a <= w_sel_coef;
        r_mac_b <= w_sel_opnd;
      end

      // Result register and strobe appear together during SHIFT.
      if (r_state == ST_OUT) begin
        r_out_data  <= w_result;
        r_out_valid <= 1'b1;
      end

      if (r_state == ST_SHIFT) begin
        r_x2 <= r_x1;
        r_x1 <= r_x0;
        r_y2 <= r_y1;
        r_y1 <= r_out_data;
      end
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign mac_start = (r_state == ST_ISSUE);
  // Single-cycle clear on CLR entry even if CLR stretches waiting on mac_ready.
  assign mac_clr   = reset | ((r_state == ST_CLR) & ~r_clr_done);
  assign mac_a     = r_mac_a;
  assign mac_b     = r_mac_b;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

endmodule : iir_tap_seq
`default_nettype wire
